// File: rtl/encoder.sv
// rtl/encoder.sv - registered priority encoder, highest set bit of in wins
// Optional multi_hot output is enabled by defining ENCODER_MULTIHOT_FLAG_EN.
module encoder #(
  parameter int IN_W  = 8,
  parameter int OUT_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  input  logic             rst_n,
  output logic             valid
`ifdef ENCODER_MULTIHOT_FLAG_EN
  ,
  output logic             multi_hot
`endif
);

  logic [OUT_W-1:0] w_idx;
  logic             w_any;

  // Ascending scan so the last (most significant) set bit overwrites lower ones.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (in[i]) begin
        w_idx = OUT_W'(i);
      end
    end
  end

  assign w_any = |in;

  logic [OUT_W-1:0] r_out;
  logic             r_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else if (en) begin
      r_out   <= w_idx;
      r_valid <= w_any;
    end
  end

  assign out   = r_out;
  assign valid = r_valid;

`ifdef ENCODER_MULTIHOT_FLAG_EN
  logic w_multi;
  logic r_multi_hot;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi = |(in & (in - IN_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_multi_hot <= 1'b0;
    end else if (en) begin
      r_multi_hot <= w_multi;
    end
  end

  assign multi_hot = r_multi_hot;
`endif

endmodule

// File: tb/tb_encoder.sv
// tb/tb_encoder.sv - directed self-checking bench for encoder
// Checks multi_hot too when ENCODER_MULTIHOT_FLAG_EN is defined.
module tb_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] in_v;
  logic [2:0] out_w;
  logic       valid_w;
`ifdef ENCODER_MULTIHOT_FLAG_EN
  logic       mh_w;
`endif

  int checks = 0;
  int errors = 0;

  encoder #(.IN_W(8)) dut (
    .clk   (clk),
    .en    (en),
    .in    (in_v),
    .out   (out_w),
    .rst_n (rst_n),
    .valid (valid_w)
`ifdef ENCODER_MULTIHOT_FLAG_EN
    ,
    .multi_hot (mh_w)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic [7:0] v);
    rst_n = r;
    en    = e;
    in_v  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] eo, input logic ev);
    checks++;
    assert (out_w === eo) else begin
      errors++;
      $error("FAIL %s out: got %0h expected %0h", tag, out_w, eo);
    end
    checks++;
    assert (valid_w === ev) else begin
      errors++;
      $error("FAIL %s valid: got %0b expected %0b", tag, valid_w, ev);
    end
  endtask

`ifdef ENCODER_MULTIHOT_FLAG_EN
  task automatic chk_mh(input string tag, input logic em);
    checks++;
    assert (mh_w === em) else begin
      errors++;
      $error("FAIL %s multi_hot: got %0b expected %0b", tag, mh_w, em);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    in_v  = 8'hff;

    step(1'b0, 1'b1, 8'hff); chk("reset_e1", 3'd0, 1'b0);
`ifdef ENCODER_MULTIHOT_FLAG_EN
    chk_mh("reset_mh", 1'b0);
`endif
    step(1'b0, 1'b1, 8'hff); chk("reset_e2", 3'd0, 1'b0);
    step(1'b1, 1'b1, 8'hff); chk("release_ff", 3'd7, 1'b1);

    step(1'b1, 1'b1, 8'h04); chk("hold_load", 3'd2, 1'b1);
    step(1'b1, 1'b0, 8'h80); chk("hold_1", 3'd2, 1'b1);
    step(1'b1, 1'b0, 8'h80); chk("hold_2", 3'd2, 1'b1);
    step(1'b1, 1'b0, 8'h80); chk("hold_3", 3'd2, 1'b1);

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 8'(1 << i));
      chk($sformatf("sweep_%0d", i), 3'(i), 1'b1);
`ifdef ENCODER_MULTIHOT_FLAG_EN
      chk_mh($sformatf("sweep_mh_%0d", i), 1'b0);
`endif
    end

    step(1'b1, 1'b1, 8'h03); chk("prio_03", 3'd1, 1'b1);
`ifdef ENCODER_MULTIHOT_FLAG_EN
    chk_mh("mh_03", 1'b1);
`endif
    step(1'b1, 1'b1, 8'h05); chk("prio_05", 3'd2, 1'b1);
`ifdef ENCODER_MULTIHOT_FLAG_EN
    chk_mh("mh_05", 1'b1);
`endif
    step(1'b1, 1'b1, 8'h0c); chk("prio_0c", 3'd3, 1'b1);
`ifdef ENCODER_MULTIHOT_FLAG_EN
    chk_mh("mh_0c", 1'b1);
`endif
    step(1'b1, 1'b1, 8'ha0); chk("prio_a0", 3'd7, 1'b1);
`ifdef ENCODER_MULTIHOT_FLAG_EN
    chk_mh("mh_a0", 1'b1);
`endif
    step(1'b1, 1'b1, 8'h02); chk("prio_02", 3'd1, 1'b1);
`ifdef ENCODER_MULTIHOT_FLAG_EN
    chk_mh("mh_02", 1'b0);
`endif
    step(1'b1, 1'b1, 8'hff); chk("prio_ff", 3'd7, 1'b1);

    step(1'b1, 1'b1, 8'h00); chk("zero", 3'd0, 1'b0);
    step(1'b1, 1'b1, 8'h01); chk("one", 3'd0, 1'b1);

    step(1'b1, 1'b1, 8'ha0); chk("mid_load", 3'd7, 1'b1);
    step(1'b0, 1'b1, 8'ha0); chk("mid_reset", 3'd0, 1'b0);
`ifdef ENCODER_MULTIHOT_FLAG_EN
    chk_mh("mid_reset_mh", 1'b0);
`endif
    step(1'b1, 1'b1, 8'ha0); chk("mid_reenc", 3'd7, 1'b1);
    step(1'b0, 1'b0, 8'hff); chk("reset_no_en", 3'd0, 1'b0);
    step(1'b1, 1'b0, 8'hff); chk("hold_after_rst", 3'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/encoder.md
Name: encoder

Overview:
- Registered 8-to-3 priority encoder with enable.
- Each rising clock edge with enable high: samples an 8-bit request vector and registers the index of its highest set bit.
- Used wherever a one-hot or multi-hot request vector must be turned into a binary index, e.g. arbitration or interrupt-source selection.
- Output is registered; downstream logic sees a stable index for the whole cycle.

Parameters:
- IN_W, 8, width of input vector; must be a power of two, at least 2.
- OUT_W, $clog2(IN_W) (3 at default), width of encoded index output.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- en  input  1  enable; when 1 the input is sampled and encoded this edge.
- in  input  IN_W  request vector; bit i is request i.
- out  output  OUT_W  registered index of the highest set bit of in.
- valid  output  1  registered; 1 when the captured in had at least one bit set.
- Positional order is clk, en, in, out, rst_n, valid, so existing positional instantiations (clk, en, in, out) remain valid.

Behaviour:
- Reset: on posedge clk with rst_n=0, out <= 0 and valid <= 0. Reset overrides en.
- Encode: on posedge clk with rst_n=1 and en=1:
  - out <= index of the most-significant set bit of in (MSB has highest priority).
  - valid <= |in.
- Zero input: with en=1 and in=0, out <= 0 and valid <= 0.
- Hold: with en=0 and rst_n=1, out and valid keep their previous values. The input is ignored.
- Latency: exactly one clock. A value applied before edge N is visible on out/valid after edge N.
- No combinational path from in or en to out or valid.
- X-safety: a reset cycle always produces known outputs.
- Encoding is purely a function of the sampled in; there is no memory of earlier inputs.
- Examples, IN_W=8:
  - 0x01 -> 0
  - 0x02 -> 1
  - 0x03 -> 1
  - 0x04 -> 2
  - 0x05 -> 2
  - 0x0c -> 3
  - 0xa0 -> 7
  - 0x80 -> 7
  - 0xff -> 7
- Reset asserted mid-stream clears outputs on that same edge. The first encode after release happens on the next edge with en=1.

Optional Feature:
- Macro: ENCODER_MULTIHOT_FLAG_EN.
- When defined:
  - Adds output multi_hot (1 bit, registered, positioned after valid).
  - On an encode edge, multi_hot <= 1 if more than one bit of in is set, else 0.
  - Resets to 0 and holds when en=0, like out.
- When undefined:
  - Port multi_hot does not exist.
  - No related logic is generated.

Test Plan:
- Reset: rst_n=0 for 2 edges with en=1, in=0xff -> out=0, valid=0. Release rst_n, same input -> out=7, valid=1 after the next edge.
- Disabled hold: encode in=0x04 (out=2), then en=0 with in=0x80 for 3 edges -> out stays 2, valid stays 1.
- Single-bit sweep: en=1, in=0x01,0x02,0x04,…,0x80 on consecutive edges -> out=0..7, each appearing one cycle after its input, valid=1.
- Priority: in=0x03 -> 1; 0x05 -> 2; 0x0c -> 3; 0xa0 -> 7; valid=1 for all. With the macro defined, multi_hot=1 for all four, and 0x02 -> multi_hot=0.
- Zero input: en=1, in=0x00 -> out=0, valid=0, distinguishable from in=0x01 (out=0, valid=1).
- Reset mid-operation: in=0xa0 encoded (out=7), then rst_n=0 for one edge with en=1 -> out=0, valid=0 that edge. Next edge with rst_n=1 re-encodes to out=7.
